branch_issue_ctrl: RTL and testbench

//  Issue scheduler in front of the 3-stage branch unit. Buffers decoded branch ops in a small FIFO.

---
 rtl/branch_pkg.sv | 37 +++
 rtl/branch_issue_ctrl_if.sv | 32 +++
 rtl/branch_issue_fifo.sv | 52 +++++
 rtl/branch_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_branch_issue_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch issue scheduler: unit/format codes, hazard bits,
// FSM states and the CTR/LR hazard predicate.
package branch_pkg;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_LSU    = 3'd1,
        FU_BRANCH = 3'd2,
        FU_FPU    = 3'd3
    } fu_code_e;

    typedef enum logic [1:0] {
        FMT_I  = 2'd0,
        FMT_B  = 2'd1,
        FMT_XL = 2'd2
    } instr_fmt_e;

    typedef struct packed {
        logic ctrRd;
        logic ctrWr;
        logic lrRd;
        logic lrWr;
    } hazard_bits_t;

    localparam int HZ_W = $bits(hazard_bits_t);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // CTR read-after-write, CTR write-after-write and LR read-after-write block issue.
    function automatic logic branch_hazard(hazard_bits_t head, logic ctr_busy, logic lr_busy);
        return (head.ctrRd & ctr_busy) | (head.ctrWr & ctr_busy) | (head.lrRd & lr_busy);
    endfunction

endpackage

// File: rtl/branch_issue_ctrl_if.sv
// Decode-side request handshake and branch-unit issue/redirect signals.
interface branch_issue_ctrl_if #(
    parameter int PAYLOAD_WIDTH = 128,
    parameter int ADDR_WIDTH    = 64
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [PAYLOAD_WIDTH-1:0] req_payload_i;
    logic [ADDR_WIDTH-1:0]    req_addr_i;
    logic                     req_ctrRd_i;
    logic                     req_ctrWr_i;
    logic                     req_lrRd_i;
    logic                     req_lrWr_i;
    logic                     bu_enable_o;
    logic [PAYLOAD_WIDTH-1:0] bu_payload_o;
    logic [ADDR_WIDTH-1:0]    bu_addr_o;
    logic                     bu_isBranching_i;

    modport slave (
        input  req_valid_i, req_payload_i, req_addr_i,
        input  req_ctrRd_i, req_ctrWr_i, req_lrRd_i, req_lrWr_i,
        input  bu_isBranching_i,
        output req_ready_o, bu_enable_o, bu_payload_o, bu_addr_o
    );

    modport master (
        output req_valid_i, req_payload_i, req_addr_i,
        output req_ctrRd_i, req_ctrWr_i, req_lrRd_i, req_lrWr_i,
        output bu_isBranching_i,
        input  req_ready_o, bu_enable_o, bu_payload_o, bu_addr_o
    );
endinterface

// File: rtl/branch_issue_fifo.sv
// Synchronous FIFO with clear, exposing the head entry and the fill count.
// The caller guarantees no push when full and no pop when empty.
module branch_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Pointers and count; power-of-two depth makes pointer wrap free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else if (clr_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_issue_ctrl.sv
// Branch issue scheduler: FIFO-buffered, CTR/LR hazard-gated single issue into the branch unit.
// Hazard-stall statistics are built only when BRANCH_ISSUE_STATS_EN is defined.
module branch_issue_ctrl
    import branch_pkg::*;
#(
    parameter int QUEUE_DEPTH   = 4,
    parameter int PIPE_DEPTH    = 3,
    parameter int PAYLOAD_WIDTH = 128,
    parameter int ADDR_WIDTH    = 64,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    branch_issue_ctrl_if.slave            bus,
    input  logic                          flush_i,
    output logic [$clog2(QUEUE_DEPTH):0]  occupancy_o,
    output logic [31:0]                   stallCycles_o
);
    localparam int CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam int ENTRY_W = PAYLOAD_WIDTH + ADDR_WIDTH + HZ_W;
    localparam int FCW     = $clog2(FLUSH_CYCLES + 1);
    // An op in the commit stage has written CTR/LR before anything issued now reads it,
    // so only the stages ahead of commit are tracked.
    localparam int SB_LEN  = PIPE_DEPTH - 1;

    state_e             state_q, state_d;
    logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [SB_LEN-1:0]  sb_ctr_q, sb_ctr_d;
    logic [SB_LEN-1:0]  sb_lr_q, sb_lr_d;
    logic [ENTRY_W-1:0] wr_entry_s, head_entry_s;
    logic [CW-1:0]      count_s;
    hazard_bits_t       req_hz_s, head_hz_s;
    logic               redirect_s, run_s, nonempty_s, hazard_s;
    logic               issue_s, push_s, clear_s;

    logic                     bu_enable_q;
    logic [PAYLOAD_WIDTH-1:0] bu_payload_q;
    logic [ADDR_WIDTH-1:0]    bu_addr_q;

    assign req_hz_s   = hazard_bits_t'{ctrRd: bus.req_ctrRd_i, ctrWr: bus.req_ctrWr_i,
                                       lrRd: bus.req_lrRd_i,   lrWr: bus.req_lrWr_i};
    assign wr_entry_s = {bus.req_payload_i, bus.req_addr_i, req_hz_s};
    assign head_hz_s  = hazard_bits_t'(head_entry_s[HZ_W-1:0]);

    assign redirect_s = bus.bu_isBranching_i | flush_i;
    assign run_s      = (state_q == RUN);
    assign nonempty_s = (count_s != {CW{1'b0}});
    assign hazard_s   = branch_hazard(head_hz_s, |sb_ctr_q, |sb_lr_q);
    assign issue_s    = run_s & nonempty_s & ~hazard_s & ~redirect_s;
    assign push_s     = bus.req_valid_i & bus.req_ready_o & ~redirect_s;
    assign clear_s    = redirect_s | ~run_s;

    assign bus.req_ready_o = ~reset_i & run_s & (count_s < CW'(QUEUE_DEPTH));

    branch_issue_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .clr_i   (clear_s),
        .push_i  (push_s),
        .pop_i   (issue_s),
        .wdata_i (wr_entry_s),
        .head_o  (head_entry_s),
        .count_o (count_s)
    );

    // Next state: any redirect (re)arms the flush timer.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (redirect_s) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
                end else begin
                    state_d     = RUN;
                end
            end
            FLUSH: begin
                if (redirect_s) begin
                    flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
                end else if (flush_cnt_q == {FCW{1'b0}}) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = {FCW{1'b0}};
            end
        endcase
    end

    // Scoreboard shift: slot 0 takes the write bits of the op issuing this cycle.
    always_comb begin
        sb_ctr_d = {SB_LEN{1'b0}};
        sb_lr_d  = {SB_LEN{1'b0}};
        if (!clear_s) begin
            sb_ctr_d = (sb_ctr_q << 1) | SB_LEN'(issue_s & head_hz_s.ctrWr);
            sb_lr_d  = (sb_lr_q  << 1) | SB_LEN'(issue_s & head_hz_s.lrWr);
        end else begin
            sb_ctr_d = {SB_LEN{1'b0}};
            sb_lr_d  = {SB_LEN{1'b0}};
        end
    end

    // Control state registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            flush_cnt_q <= {FCW{1'b0}};
            sb_ctr_q    <= {SB_LEN{1'b0}};
            sb_lr_q     <= {SB_LEN{1'b0}};
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            sb_ctr_q    <= sb_ctr_d;
            sb_lr_q     <= sb_lr_d;
        end
    end

    // Registered issue port; payload and address hold between issues.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bu_enable_q  <= 1'b0;
            bu_payload_q <= {PAYLOAD_WIDTH{1'b0}};
            bu_addr_q    <= {ADDR_WIDTH{1'b0}};
        end else begin
            bu_enable_q <= issue_s;
            if (issue_s) begin
                bu_payload_q <= head_entry_s[ENTRY_W-1 -: PAYLOAD_WIDTH];
                bu_addr_q    <= head_entry_s[HZ_W +: ADDR_WIDTH];
            end
        end
    end

    assign bus.bu_enable_o  = bu_enable_q;
    assign bus.bu_payload_o = bu_payload_q;
    assign bus.bu_addr_o    = bu_addr_q;
    assign occupancy_o      = count_s;

`ifdef BRANCH_ISSUE_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a queued head is held back by a hazard.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q <= 32'd0;
        end else if (run_s && nonempty_s && hazard_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stallCycles_o = stall_q;
`else
    assign stallCycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Directed bench for branch_issue_ctrl: hazard table plus flush/full/reset sequences.
module tb_branch_issue_ctrl;
    localparam int PW = 128;
    localparam int AW = 64;
`ifdef BRANCH_ISSUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset_i;
    logic        flush_i;
    logic [2:0]  occupancy;
    logic [31:0] stall_cycles;

    branch_issue_ctrl_if #(.PAYLOAD_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

    branch_issue_ctrl #(
        .QUEUE_DEPTH   (4),
        .PIPE_DEPTH    (3),
        .PAYLOAD_WIDTH (PW),
        .ADDR_WIDTH    (AW),
        .FLUSH_CYCLES  (2)
    ) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .bus           (bus),
        .flush_i       (flush_i),
        .occupancy_o   (occupancy),
        .stallCycles_o (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // hz bit order: {ctrRd, ctrWr, lrRd, lrWr}
    typedef struct {
        logic [3:0] a_hz;
        logic [3:0] b_hz;
        int         exp_gap;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [PW-1:0] p, input logic [AW-1:0] a,
                           input logic [3:0] hz);
        bus.req_valid_i   = v;
        bus.req_payload_i = p;
        bus.req_addr_i    = a;
        bus.req_ctrRd_i   = hz[3];
        bus.req_ctrWr_i   = hz[2];
        bus.req_lrRd_i    = hz[1];
        bus.req_lrWr_i    = hz[0];
    endtask

    initial begin
        int b_edge;
        int exp_stall;
        logic [PW-1:0] pa, pb;
        logic [AW-1:0] aa;

        vec[0] = '{4'b0000, 4'b0000, 1};
        vec[1] = '{4'b0100, 4'b1000, 3};
        vec[2] = '{4'b0100, 4'b0100, 3};
        vec[3] = '{4'b0001, 4'b0010, 3};
        vec[4] = '{4'b0001, 4'b0001, 1};
        vec[5] = '{4'b0100, 4'b0010, 1};
        vec[6] = '{4'b0001, 4'b1000, 1};
        vec[7] = '{4'b1000, 4'b0100, 1};
        vec[8] = '{4'b1111, 4'b1000, 3};

        reset_i = 1'b1;
        flush_i = 1'b0;
        bus.bu_isBranching_i = 1'b0;
        set_req(1'b0, '0, '0, 4'b0000);
        #2;
        check("rst_ready", bus.req_ready_o, 0);
        check("rst_enable", bus.bu_enable_o, 0);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall_cycles, 0);
        #10;
        reset_i = 1'b0;
        #1;
        check("rst_release_ready", bus.req_ready_o, 1);
        step();

        // Back-to-back pairs: B issues 1 edge after A, or 3 when blocked by A.
        exp_stall = 0;
        for (int i = 0; i < 9; i++) begin
            pa = 128'h1000 + 128'(i);
            pb = 128'h2000 + 128'(i);
            aa = 64'h4000 + 64'(i * 4);
            set_req(1'b1, pa, aa, vec[i].a_hz);
            step();
            check($sformatf("v%0d_occ_after_push", i), occupancy, 1);
            check($sformatf("v%0d_no_same_cycle_issue", i), bus.bu_enable_o, 0);
            set_req(1'b1, pb, 64'h5000, vec[i].b_hz);
            step();
            check($sformatf("v%0d_a_enable", i), bus.bu_enable_o, 1);
            check($sformatf("v%0d_a_payload", i), bus.bu_payload_o, pa);
            check($sformatf("v%0d_a_addr", i), bus.bu_addr_o, aa);
            set_req(1'b0, '0, '0, 4'b0000);
            b_edge = 0;
            for (int k = 2; k <= 6; k++) begin
                step();
                if (bus.bu_enable_o && b_edge == 0) begin
                    b_edge = k;
                    check($sformatf("v%0d_b_payload", i), bus.bu_payload_o, pb);
                end
            end
            check($sformatf("v%0d_b_issue_edge", i), b_edge, 1 + vec[i].exp_gap);
            check($sformatf("v%0d_occ_drained", i), occupancy, 0);
            if (vec[i].exp_gap == 3) exp_stall += 2;
            check($sformatf("v%0d_stall", i), stall_cycles, STATS ? exp_stall : 0);
        end

        // Fill with CTR writers so every head is WAW-blocked.
        for (int j = 0; j < 6; j++) begin
            check($sformatf("fill%0d_ready", j), bus.req_ready_o, 1);
            set_req(1'b1, 128'h3000 + 128'(j), 64'h8000 + 64'(j * 4), 4'b0100);
            step();
        end
        check("full_ready", bus.req_ready_o, 0);
        check("full_occ", occupancy, 4);
        set_req(1'b1, 128'hDEAD, 64'hBAD, 4'b0000);
        step();
        check("full_reject_occ", occupancy, 4);
        check("full_no_issue", bus.bu_enable_o, 0);
        set_req(1'b0, '0, '0, 4'b0000);
        step();
        check("full_c_issue", bus.bu_enable_o, 1);
        check("full_c_payload", bus.bu_payload_o, 128'h3002);
        check("three_queued", occupancy, 3);

        // Redirect with three queued ops.
        bus.bu_isBranching_i = 1'b1;
        step();
        bus.bu_isBranching_i = 1'b0;
        check("redir_occ", occupancy, 0);
        check("redir_ready0", bus.req_ready_o, 0);
        check("redir_en0", bus.bu_enable_o, 0);
        step();
        check("redir_ready1", bus.req_ready_o, 0);
        check("redir_en1", bus.bu_enable_o, 0);
        step();
        check("redir_ready_back", bus.req_ready_o, 1);
        check("redir_occ_back", occupancy, 0);
        check("redir_en2", bus.bu_enable_o, 0);

        // A second flush during FLUSH restarts the count.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("restart_ready0", bus.req_ready_o, 0);
        step();
        check("restart_ready1", bus.req_ready_o, 0);
        step();
        check("restart_ready_back", bus.req_ready_o, 1);

        // Redirect collides with a would-be issue and a push.
        set_req(1'b1, 128'h5000, 64'h5000, 4'b0000);
        step();
        check("coll_occ1", occupancy, 1);
        bus.bu_isBranching_i = 1'b1;
        set_req(1'b1, 128'h5001, 64'h5004, 4'b0000);
        step();
        bus.bu_isBranching_i = 1'b0;
        set_req(1'b0, '0, '0, 4'b0000);
        check("coll_no_issue", bus.bu_enable_o, 0);
        check("coll_occ0", occupancy, 0);
        step();
        check("coll_en_flush", bus.bu_enable_o, 0);
        step();
        check("coll_ready_back", bus.req_ready_o, 1);
        check("coll_occ_back", occupancy, 0);
        check("coll_en_back", bus.bu_enable_o, 0);

        // Asynchronous reset in the middle of FLUSH.
        set_req(1'b1, 128'h6000, 64'h6000, 4'b0000);
        step();
        set_req(1'b0, '0, '0, 4'b0000);
        step();
        check("pre_rst_issue", bus.bu_payload_o, 128'h6000);
        bus.bu_isBranching_i = 1'b1;
        step();
        bus.bu_isBranching_i = 1'b0;
        #3;
        reset_i = 1'b1;
        #1;
        check("arst_ready", bus.req_ready_o, 0);
        check("arst_en", bus.bu_enable_o, 0);
        check("arst_payload", bus.bu_payload_o, 0);
        check("arst_addr", bus.bu_addr_o, 0);
        check("arst_occ", occupancy, 0);
        check("arst_stall", stall_cycles, 0);
        step();
        #3;
        reset_i = 1'b0;
        #1;
        check("arst_release_ready", bus.req_ready_o, 1);
        check("arst_release_occ", occupancy, 0);
        set_req(1'b1, 128'h6001, 64'h6004, 4'b0000);
        step();
        set_req(1'b0, '0, '0, 4'b0000);
        step();
        check("post_rst_issue", bus.bu_enable_o, 1);
        check("post_rst_payload", bus.bu_payload_o, 128'h6001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
